game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
- Central timing controller for the dodge game. Replaces free-running divided clocks with single-cycle tick enables in the CLK domain.
- Sequences game speed through five difficulty levels: 1, 3, 5, 7 and 10 Hz.
- Runs the game-state FSM (idle/run/pause/over) and keeps the score.
- Also emits a fixed 1 kHz scan strobe for display multiplexing.

Parameters:
- CLK_FREQ_HZ, 50000000, input clock frequency; all divisors are derived from it.
- TICKS_PER_LEVEL, 20, game ticks survived before the level advances.
- SCORE_W, 10, score counter width.
- SCORE_MAX, 999, score saturation value (3-digit display).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- start  in  1  level-sampled start request.
- pause  in  1  pause toggle request (see Optional Feature).
- hit  in  1  collision from game logic.
- game_tick  out  1  one-cycle pulse at the current level rate.
- scan_tick  out  1  one-cycle pulse at 1 kHz.
- level  out  3  current level, 0..4.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.
- score  out  SCORE_W  game ticks survived.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: state=IDLE, level=0, score=0, game_tick=0, scan_tick=0; both counters=0.
- Divisors:
  - DIV[L] = CLK_FREQ_HZ / {1,3,5,7,10}[L], integer truncation.
  - SCAN_DIV = CLK_FREQ_HZ / 1000.
  - Counters are 26 bits.
- Scan counter:
  - Free-runs in every state.
  - When it equals SCAN_DIV-1, scan_tick=1 for exactly one cycle and the counter wraps to 0.
- Game counter:
  - Counts only in RUN.
  - When it equals DIV[level]-1 with no hit that cycle: game_tick=1 for one cycle, counter wraps to 0, score increments (saturating at SCORE_MAX), and the per-level tick count increments.
  - Outputs are registered; game_tick asserts in the cycle after the terminal count is reached.
  - First game_tick after entering RUN comes DIV[level] cycles after the start cycle.
- Level advance:
  - When the per-level tick count reaches TICKS_PER_LEVEL: level increments (saturates at 4), the per-level count clears and the game counter clears.
  - The new period starts fresh; no partial period is carried over.
  - At level 4 the per-level count keeps wrapping with no effect.
- FSM transitions:
  - IDLE: start -> RUN.
  - RUN: hit -> OVER, with game counter frozen.
  - OVER: start -> RUN with score=0, level=0 and both game counters=0.
  - IDLE start likewise clears these.
  - start in RUN or PAUSE is ignored.
- Simultaneous events:
  - hit in the same cycle as a terminal count: hit wins; no game_tick and no score increment.
  - hit and start together in RUN: go to OVER.
  - hit outside RUN is ignored.
- Reset mid-operation returns everything to reset values on the next edge, regardless of state.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - pause in RUN -> PAUSE; the game counter holds its value and game_tick=0.
  - pause in PAUSE -> RUN; counting resumes from the held value.
  - pause is edge-detected internally: one toggle per rising edge of pause.
  - hit is ignored in PAUSE.
- Not defined:
  - The pause port exists but is ignored.
  - The PAUSE encoding is never produced.
  - The edge-detect register is not built.

Decomposition:
- Package game_timing_pkg:
  - state enum (IDLE/RUN/PAUSE/OVER, 2 bits).
  - LEVEL_MAX=4.
  - rate table {1,3,5,7,10}, SCAN_HZ=1000.
  - divisor function of (CLK_FREQ_HZ, rate).
- Sub-module tick_gen:
  - Inputs: programmable divisor, enable, synchronous clear.
  - Output: terminal-count pulse.
  - Instantiated twice: once for game, once for scan (scan enable tied high).

Test Plan:
All scenarios use CLK_FREQ_HZ=10000, giving DIV = 10000, 3333, 2000, 1428, 1000 and SCAN_DIV=10; TICKS_PER_LEVEL=3.
- Reset, then idle 100 cycles -> scan_tick every 10 cycles, game_tick never, state=0, score=0.
- start pulse, run 30000 cycles -> game_tick at 10000, 20000, 30000 cycles after start; level becomes 1 right after the third tick; next tick 3333 cycles later.
- Run until level 4 is reached, then 5 more ticks -> level stays 4; tick spacing stays 1000; score increments each tick.
- hit asserted in the same cycle as a terminal count at level 0 -> no game_tick, score unchanged, state=3; start -> state=1, score=0, level=0.
- RST asserted mid-RUN at level 2 with score=7 -> next cycle state=0, level=0, score=0; scan counter restarts, so the first scan_tick comes 10 cycles after reset deassert.
- GAME_PAUSE_EN defined: pause 4000 cycles into level 0 and hold for 5000 cycles, then pause again -> no tick while paused; first tick 6000 cycles after resume; state reads 2 while paused.

Source files
------------

// File: rtl/game_timing_pkg.sv
// rtl/game_timing_pkg.sv - shared state encoding, rate table and divisor helper for the game tick scheduler
package game_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int CNT_W      = 26;
    localparam int LEVEL_MAX  = 4;
    localparam int NUM_LEVELS = 5;
    localparam int SCAN_HZ    = 1000;

    // Game speed in Hz for each difficulty level, slowest first.
    localparam int unsigned LEVEL_RATE [NUM_LEVELS] = '{1, 3, 5, 7, 10};

    // Cycles per tick for a given rate; integer truncation keeps the rate slightly fast, never slow.
    function automatic logic [CNT_W-1:0] tick_divisor(input int unsigned clk_hz, input int unsigned rate_hz);
        int unsigned q;
        q = clk_hz / rate_hz;
        return q[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - programmable terminal-count divisor producing a single-cycle enable
module tick_gen
    import game_timing_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;

    // Terminal count stays combinational so the parent registers it together with its own state.
    assign tc = en && (cnt_q == (div - CNT_W'(1)));

    // Count while enabled, wrap on terminal count; clear has priority over counting.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt_q <= '0;
        end else if (tc) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - game state FSM, level sequencing, score and tick enables (pause behind GAME_PAUSE_EN)
module game_tick_scheduler
    import game_timing_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 50000000,
    parameter int TICKS_PER_LEVEL = 20,
    parameter int SCORE_W         = 10,
    parameter int SCORE_MAX       = 999
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               pause,
    input  logic               hit,
    output logic               game_tick,
    output logic               scan_tick,
    output logic [2:0]         level,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score
);

    localparam int TPL_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

    localparam logic [CNT_W-1:0] DIV_L0   = tick_divisor(CLK_FREQ_HZ, LEVEL_RATE[0]);
    localparam logic [CNT_W-1:0] DIV_L1   = tick_divisor(CLK_FREQ_HZ, LEVEL_RATE[1]);
    localparam logic [CNT_W-1:0] DIV_L2   = tick_divisor(CLK_FREQ_HZ, LEVEL_RATE[2]);
    localparam logic [CNT_W-1:0] DIV_L3   = tick_divisor(CLK_FREQ_HZ, LEVEL_RATE[3]);
    localparam logic [CNT_W-1:0] DIV_L4   = tick_divisor(CLK_FREQ_HZ, LEVEL_RATE[4]);
    localparam logic [CNT_W-1:0] SCAN_DIV = tick_divisor(CLK_FREQ_HZ, SCAN_HZ);

    game_state_t        state_q;
    game_state_t        state_d;
    logic               run_clear;
    logic               pause_rise;
    logic [2:0]         level_q;
    logic [SCORE_W-1:0] score_q;
    logic [TPL_W-1:0]   tick_cnt_q;
    logic               game_tick_q;
    logic               scan_tick_q;
    logic [CNT_W-1:0]   game_div;
    logic               game_en;
    logic               game_clr;
    logic               game_tc;
    logic               scan_tc;
    logic               level_up;

`ifdef GAME_PAUSE_EN
    logic pause_q;

    // Remember last pause level so a held button toggles only once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause;
        end
    end

    assign pause_rise = pause && !pause_q;
`else
    logic unused_pause;

    assign unused_pause = pause;
    assign pause_rise   = 1'b0;
`endif

    // Next-state logic; a fresh game from IDLE or OVER also clears score, level and counters.
    always_comb begin
        state_d   = state_q;
        run_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d   = ST_RUN;
                    run_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (hit) begin
                    state_d = ST_OVER;
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_rise) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Select the period for the current difficulty level.
    always_comb begin
        game_div = DIV_L4;
        case (level_q)
            3'd0:    game_div = DIV_L0;
            3'd1:    game_div = DIV_L1;
            3'd2:    game_div = DIV_L2;
            3'd3:    game_div = DIV_L3;
            default: game_div = DIV_L4;
        endcase
    end

    // A hit freezes the counter in the same cycle so a coincident terminal count is lost.
    assign game_en  = (state_q == ST_RUN) && !hit;
    assign level_up = game_tc && (tick_cnt_q == TPL_W'(TICKS_PER_LEVEL - 1));
    assign game_clr = run_clear || level_up;

    tick_gen u_game_div (
        .CLK (CLK),
        .RST (RST),
        .en  (game_en),
        .clr (game_clr),
        .div (game_div),
        .tc  (game_tc)
    );

    tick_gen u_scan_div (
        .CLK (CLK),
        .RST (RST),
        .en  (1'b1),
        .clr (1'b0),
        .div (SCAN_DIV),
        .tc  (scan_tc)
    );

    // Register the tick pulses so outputs are glitch-free single-cycle enables.
    always_ff @(posedge CLK) begin
        if (RST) begin
            game_tick_q <= 1'b0;
            scan_tick_q <= 1'b0;
        end else begin
            game_tick_q <= game_tc;
            scan_tick_q <= scan_tc;
        end
    end

    // Score and level bookkeeping on every surviving game tick.
    always_ff @(posedge CLK) begin
        if (RST || run_clear) begin
            level_q    <= '0;
            score_q    <= '0;
            tick_cnt_q <= '0;
        end else if (game_tc) begin
            if (score_q != SCORE_W'(SCORE_MAX)) begin
                score_q <= score_q + SCORE_W'(1);
            end
            if (level_up) begin
                tick_cnt_q <= '0;
                if (level_q != 3'(LEVEL_MAX)) begin
                    level_q <= level_q + 3'd1;
                end
            end else begin
                tick_cnt_q <= tick_cnt_q + TPL_W'(1);
            end
        end
    end

    assign game_tick = game_tick_q;
    assign scan_tick = scan_tick_q;
    assign level     = level_q;
    assign state     = state_q;
    assign score     = score_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - directed self-checking bench for game_tick_scheduler (pause checks follow GAME_PAUSE_EN)
module tb_game_tick_scheduler;

    localparam int DIVS [5] = '{10000, 3333, 2000, 1428, 1000};

    logic       CLK = 1'b0;
    int         total = 0;
    int         bad   = 0;

    logic       a_rst, a_start, a_pause, a_hit;
    logic       a_game_tick, a_scan_tick;
    logic [2:0] a_level;
    logic [1:0] a_state;
    logic [9:0] a_score;

    logic       b_rst, b_start, b_pause, b_hit;
    logic       b_game_tick, b_scan_tick;
    logic [2:0] b_level;
    logic [1:0] b_state;
    logic [9:0] b_score;

    game_tick_scheduler #(
        .CLK_FREQ_HZ(10000), .TICKS_PER_LEVEL(3), .SCORE_W(10), .SCORE_MAX(999)
    ) dut_a (
        .CLK(CLK), .RST(a_rst), .start(a_start), .pause(a_pause), .hit(a_hit),
        .game_tick(a_game_tick), .scan_tick(a_scan_tick),
        .level(a_level), .state(a_state), .score(a_score)
    );

    game_tick_scheduler #(
        .CLK_FREQ_HZ(10000), .TICKS_PER_LEVEL(3), .SCORE_W(10), .SCORE_MAX(999)
    ) dut_b (
        .CLK(CLK), .RST(b_rst), .start(b_start), .pause(b_pause), .hit(b_hit),
        .game_tick(b_game_tick), .scan_tick(b_scan_tick),
        .level(b_level), .state(b_state), .score(b_score)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_tick_a(input int max, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!a_game_tick && n < max);
    endtask

    task automatic wait_tick_b(input int max, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!b_game_tick && n < max);
    endtask

    initial begin
        fork
            begin : branch_a
                int n;
                int first;
                int scans;
                int games;
                int lv;
                int exp_lv;
                a_rst = 1'b1; a_start = 1'b0; a_pause = 1'b0; a_hit = 1'b0;
                repeat (2) @(negedge CLK);
                chk("a_rst_state", a_state, 0);
                chk("a_rst_level", a_level, 0);
                chk("a_rst_score", a_score, 0);
                chk("a_rst_game_tick", a_game_tick, 0);
                chk("a_rst_scan_tick", a_scan_tick, 0);
                a_rst = 1'b0;
                first = 0; scans = 0; games = 0;
                for (int i = 1; i <= 100; i++) begin
                    @(negedge CLK);
                    if (a_scan_tick) begin
                        scans++;
                        if (first == 0) first = i;
                    end
                    if (a_game_tick) games++;
                end
                chk("a_idle_first_scan", first, 10);
                chk("a_idle_scan_count", scans, 10);
                chk("a_idle_game_ticks", games, 0);
                chk("a_idle_state", a_state, 0);
                chk("a_idle_score", a_score, 0);
                a_start = 1'b1;
                @(negedge CLK);
                a_start = 1'b0;
                chk("a_run_state", a_state, 1);
                for (int t = 1; t <= 17; t++) begin
                    lv = (t - 1) / 3;
                    if (lv > 4) lv = 4;
                    exp_lv = t / 3;
                    if (exp_lv > 4) exp_lv = 4;
                    wait_tick_a(DIVS[lv] + 50, n);
                    chk($sformatf("a_tick%0d_gap", t), n, DIVS[lv]);
                    chk($sformatf("a_tick%0d_score", t), a_score, t);
                    chk($sformatf("a_tick%0d_level", t), a_level, exp_lv);
                end
            end
            begin : branch_b
                int n;
                int games;
                b_rst = 1'b1; b_start = 1'b0; b_pause = 1'b0; b_hit = 1'b0;
                repeat (2) @(negedge CLK);
                b_rst = 1'b0;
                b_hit = 1'b1;
                @(negedge CLK);
                b_hit = 1'b0;
                chk("b_idle_hit_state", b_state, 0);
                b_start = 1'b1;
                @(negedge CLK);
                b_start = 1'b0;
                repeat (9999) @(negedge CLK);
                chk("b_pre_hit_tick", b_game_tick, 0);
                b_hit = 1'b1;
                @(negedge CLK);
                b_hit = 1'b0;
                chk("b_hit_tick", b_game_tick, 0);
                chk("b_hit_score", b_score, 0);
                chk("b_hit_state", b_state, 3);
                games = 0;
                repeat (20) begin
                    @(negedge CLK);
                    games += int'(b_game_tick);
                end
                chk("b_over_ticks", games, 0);
                chk("b_over_state", b_state, 3);
                b_start = 1'b1;
                @(negedge CLK);
                b_start = 1'b0;
                chk("b_restart_state", b_state, 1);
                chk("b_restart_score", b_score, 0);
                chk("b_restart_level", b_level, 0);
                for (int t = 1; t <= 7; t++) begin
                    wait_tick_b(DIVS[(t - 1) / 3] + 50, n);
                    chk($sformatf("b_tick%0d_gap", t), n, DIVS[(t - 1) / 3]);
                end
                chk("b_pre_rst_score", b_score, 7);
                chk("b_pre_rst_level", b_level, 2);
                repeat (500) @(negedge CLK);
                b_rst = 1'b1;
                @(negedge CLK);
                b_rst = 1'b0;
                chk("b_mid_rst_state", b_state, 0);
                chk("b_mid_rst_level", b_level, 0);
                chk("b_mid_rst_score", b_score, 0);
                n = 0;
                do begin
                    @(negedge CLK);
                    n++;
                end while (!b_scan_tick && n < 50);
                chk("b_rst_first_scan", n, 10);
                b_start = 1'b1;
                @(negedge CLK);
                b_start = 1'b0;
                repeat (3999) @(negedge CLK);
                b_pause = 1'b1;
                @(negedge CLK);
`ifdef GAME_PAUSE_EN
                chk("b_paused_state", b_state, 2);
                games = 0;
                repeat (99) begin
                    @(negedge CLK);
                    games += int'(b_game_tick);
                end
                chk("b_pause_held_state", b_state, 2);
                b_pause = 1'b0;
                repeat (4900) begin
                    @(negedge CLK);
                    games += int'(b_game_tick);
                end
                chk("b_pause_ticks", games, 0);
                chk("b_pause_end_state", b_state, 2);
                b_pause = 1'b1;
                @(negedge CLK);
                b_pause = 1'b0;
                chk("b_resume_state", b_state, 1);
                wait_tick_b(6050, n);
                chk("b_resume_gap", n, 6000);
`else
                b_pause = 1'b0;
                chk("b_pause_ignored_state", b_state, 1);
                wait_tick_b(6050, n);
                chk("b_pause_ignored_gap", n, 6000);
`endif
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
